// File: rtl/bist_mux_pkg.sv
// Shared state encoding and sizing helpers for the BIST memory port multiplexer.
package bist_mux_pkg;

    typedef enum logic [1:0] {NORMAL, DRAIN, TEST, RESTORE} bist_mux_state_e;

    localparam int NUM_MEM_DEF = 4;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SEL_W = sel_width(NUM_MEM_DEF);

    function automatic int cnt_width(input int drain, input int timeout);
        int m;
        m = (drain > timeout) ? drain : timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bist_mem_mux_ctrl_if.sv
// Functional, BIST and memory-side signal bundle of the BIST memory port multiplexer.
interface bist_mem_mux_ctrl_if #(
    parameter int NUM_MEM    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    import bist_mux_pkg::*;

    localparam int SW = sel_width(NUM_MEM);

    logic                  NbarT;
    logic [NUM_MEM-1:0]    normal_ce;
    logic [NUM_MEM-1:0]    normal_we;
    logic [ADDR_WIDTH-1:0] normal_addr [NUM_MEM];
    logic [DATA_WIDTH-1:0] normal_data [NUM_MEM];
    logic                  bist_ce;
    logic                  bist_we;
    logic [ADDR_WIDTH-1:0] bist_addr;
    logic [DATA_WIDTH-1:0] bist_data;
    logic [SW-1:0]         bist_sel;
    logic [NUM_MEM-1:0]    mem_ce;
    logic [NUM_MEM-1:0]    mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr [NUM_MEM];
    logic [DATA_WIDTH-1:0] mem_data [NUM_MEM];
    logic                  test_active;
    logic                  switch_busy;
    logic                  timeout_err;

    modport master (
        output NbarT, normal_ce, normal_we, normal_addr, normal_data,
               bist_ce, bist_we, bist_addr, bist_data, bist_sel,
        input  mem_ce, mem_we, mem_addr, mem_data,
               test_active, switch_busy, timeout_err
    );

    modport slave (
        input  NbarT, normal_ce, normal_we, normal_addr, normal_data,
               bist_ce, bist_we, bist_addr, bist_data, bist_sel,
        output mem_ce, mem_we, mem_addr, mem_data,
               test_active, switch_busy, timeout_err
    );

endinterface

// File: rtl/bist_mux_quiesce_cnt.sv
// Saturating up-counter with clear and enable; tc flags the enabled cycle that
// completes TERM counted cycles.
module bist_mux_quiesce_cnt #(
    parameter int CNT_W = 2,
    parameter int TERM  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(TERM);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != SAT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = en && (cnt >= LAST);

endmodule

// File: rtl/bist_mem_mux_ctrl.sv
// Normal/BIST port multiplexer for NUM_MEM memories with a drain/restore safe-switch FSM.
// Define BIST_MUX_TIMEOUT_EN to force TEST entry after TIMEOUT drain cycles (sticky timeout_err).
//
//  state   | meaning
//  NORMAL  | functional ports drive the memories
//  DRAIN   | functional traffic still passes; waiting for DRAIN_CYCLES idle cycles
//  TEST    | BIST port drives memory bist_sel, all others quiet
//  RESTORE | all memories quiet for DRAIN_CYCLES cycles before NORMAL
module bist_mem_mux_ctrl
    import bist_mux_pkg::*;
#(
    parameter int NUM_MEM      = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bist_mem_mux_ctrl_if.slave bus
);
    localparam int CNT_W  = cnt_width(DRAIN_CYCLES, TIMEOUT);
    localparam int SEL_WL = sel_width(NUM_MEM);

    bist_mux_state_e       state, state_nxt;
    logic                  any_ce, cnt_en, idle_tc, to_tc, timeout_err_q;
    logic [NUM_MEM-1:0]    ce_d, we_d;
    logic [ADDR_WIDTH-1:0] addr_d [NUM_MEM];
    logic [DATA_WIDTH-1:0] data_d [NUM_MEM];

    assign any_ce = |bus.normal_ce;

    // One counter serves both the idle run in DRAIN and the quiet gap in RESTORE.
    assign cnt_en = ((state == DRAIN) && bus.NbarT && !any_ce) || (state == RESTORE);

    bist_mux_quiesce_cnt #(.CNT_W(CNT_W), .TERM(DRAIN_CYCLES)) u_quiesce_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!cnt_en),
        .en   (cnt_en),
        .tc   (idle_tc)
    );

`ifdef BIST_MUX_TIMEOUT_EN
    logic to_en;
    assign to_en = (state == DRAIN) && bus.NbarT;

    bist_mux_quiesce_cnt #(.CNT_W(CNT_W), .TERM(TIMEOUT)) u_timeout_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!to_en),
        .en   (to_en),
        .tc   (to_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else if (to_tc && !idle_tc) begin
            timeout_err_q <= 1'b1;
        end
    end
`else
    assign to_tc         = 1'b0;
    assign timeout_err_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL:  if (bus.NbarT) state_nxt = DRAIN;
            DRAIN: begin
                if (!bus.NbarT) begin
                    state_nxt = NORMAL;
                end else if (idle_tc || to_tc) begin
                    state_nxt = TEST;
                end
            end
            TEST:    if (!bus.NbarT) state_nxt = RESTORE;
            RESTORE: if (idle_tc) state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    always_comb begin
        ce_d   = '0;
        we_d   = '0;
        addr_d = '{default: '0};
        data_d = '{default: '0};
        case (state)
            NORMAL, DRAIN: begin
                ce_d   = bus.normal_ce;
                we_d   = bus.normal_we;
                addr_d = bus.normal_addr;
                data_d = bus.normal_data;
            end
            TEST: begin
                for (int i = 0; i < NUM_MEM; i++) begin
                    if (bus.bist_sel == SEL_WL'(i)) begin
                        ce_d[i]   = bus.bist_ce;
                        we_d[i]   = bus.bist_we;
                        addr_d[i] = bus.bist_addr;
                        data_d[i] = bus.bist_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_ce   <= '0;
            bus.mem_we   <= '0;
            bus.mem_addr <= '{default: '0};
            bus.mem_data <= '{default: '0};
        end else begin
            bus.mem_ce   <= ce_d;
            bus.mem_we   <= we_d;
            bus.mem_addr <= addr_d;
            bus.mem_data <= data_d;
        end
    end

    assign bus.test_active = (state == TEST);
    assign bus.switch_busy = (state == DRAIN) || (state == RESTORE);
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bist_mem_mux_ctrl.sv
// Scoreboard bench for bist_mem_mux_ctrl: directed vectors push expected outputs, a negedge monitor compares.
module tb_bist_mem_mux_ctrl;
    import bist_mux_pkg::*;

`ifdef BIST_MUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bist_mem_mux_ctrl_if #(.NUM_MEM(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    bist_mem_mux_ctrl #(
        .NUM_MEM(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .DRAIN_CYCLES(2), .TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        string       nm;
        logic [3:0]  ce;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ta;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t            sb_q[$];
    int              cyc = 0;
    int              n_vec = 0;
    int              n_err = 0;
    bit              end_chk = 1'b0;
    logic [SEL_W-1:0] sel_v;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs registered at the next posedge are checked at the following negedge.
    task automatic step(input string nm, input logic [3:0] ce, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic ta, input logic busy, input logic err);
        exp_t e;
        e.due = cyc + 1; e.nm = nm; e.ce = ce; e.we = we; e.addr = addr; e.data = data;
        e.ta = ta; e.busy = busy; e.err = err;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic clr_in();
        bus.normal_ce = '0;
        bus.normal_we = '0;
        for (int i = 0; i < 4; i++) begin
            bus.normal_addr[i] = '0;
            bus.normal_data[i] = '0;
        end
        bus.bist_ce = 1'b0; bus.bist_we = 1'b0;
        bus.bist_addr = '0; bus.bist_data = '0;
        sel_v = '0; bus.bist_sel = sel_v;
    endtask

    task automatic rand_in();
        bus.NbarT = 1'($urandom);
        bus.normal_ce = 4'($urandom);
        bus.normal_we = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            bus.normal_addr[i] = 8'($urandom);
            bus.normal_data[i] = 8'($urandom);
        end
        bus.bist_ce = 1'($urandom); bus.bist_we = 1'($urandom);
        bus.bist_addr = 8'($urandom); bus.bist_data = 8'($urandom);
        sel_v = SEL_W'($urandom); bus.bist_sel = sel_v;
    endtask

    exp_t        m_e;
    logic [31:0] act_a, act_d;

    always @(negedge clk) begin
        if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            m_e = sb_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                act_a[i*8 +: 8] = bus.mem_addr[i];
                act_d[i*8 +: 8] = bus.mem_data[i];
            end
            n_vec++;
            if (m_e.due != cyc ||
                {bus.mem_ce, bus.mem_we, act_a, act_d, bus.test_active, bus.switch_busy, bus.timeout_err} !==
                {m_e.ce, m_e.we, m_e.addr, m_e.data, m_e.ta, m_e.busy, m_e.err}) begin
                n_err++;
                $display("FAIL %s @cyc %0d: got ce=%b we=%b addr=%h data=%h ta=%b busy=%b err=%b, exp ce=%b we=%b addr=%h data=%h ta=%b busy=%b err=%b",
                         m_e.nm, cyc, bus.mem_ce, bus.mem_we, act_a, act_d, bus.test_active, bus.switch_busy,
                         bus.timeout_err, m_e.ce, m_e.we, m_e.addr, m_e.data, m_e.ta, m_e.busy, m_e.err);
            end
        end else if (end_chk && sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, exp 0", sb_q.size());
            sb_q.delete();
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish by 50000ns, exp finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rand_in();
        @(negedge clk);
        repeat (3) begin
            rand_in();
            step("reset_hold", 4'b0, 4'b0, 32'h0, 32'h0, 0, 0, 0);
        end
        clr_in(); bus.NbarT = 1'b0; rst_n = 1'b1;
        step("reset_release", 4'b0, 4'b0, 32'h0, 32'h0, 0, 0, 0);

        bus.normal_ce = 4'b0100; bus.normal_we = 4'b0100;
        bus.normal_addr[2] = 8'hA5; bus.normal_data[2] = 8'h05;
        step("normal_mem2", 4'b0100, 4'b0100, 32'h00A5_0000, 32'h0005_0000, 0, 0, 0);
        clr_in();
        bus.normal_ce = 4'b1001; bus.normal_we = 4'b0001;
        bus.normal_addr[0] = 8'h11; bus.normal_addr[3] = 8'h33;
        bus.normal_data[0] = 8'hAA; bus.normal_data[3] = 8'hBB;
        step("normal_mem0_3", 4'b1001, 4'b0001, 32'h3300_0011, 32'hBB00_00AA, 0, 0, 0);

        clr_in(); bus.NbarT = 1'b1;
        bus.normal_ce = 4'b0001; bus.normal_addr[0] = 8'h01; bus.normal_data[0] = 8'h10;
        step("drain_enter", 4'b0001, 4'b0, 32'h0000_0001, 32'h0000_0010, 0, 1, 0);
        clr_in();
        step("drain_idle1", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        bus.normal_ce = 4'b0010; bus.normal_addr[1] = 8'h02; bus.normal_data[1] = 8'h20;
        step("drain_ce1", 4'b0010, 4'b0, 32'h0000_0200, 32'h0000_2000, 0, 1, 0);
        clr_in();
        step("drain_idle2", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        bus.normal_ce = 4'b1000; bus.normal_addr[3] = 8'h04; bus.normal_data[3] = 8'h40;
        step("drain_ce3", 4'b1000, 4'b0, 32'h0400_0000, 32'h4000_0000, 0, 1, 0);
        clr_in();
        step("drain_quiet1", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        step("drain_to_test", 4'b0, 4'b0, 32'h0, 32'h0, 1, 0, 0);

        bus.normal_ce = 4'b1111; bus.normal_we = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.normal_addr[i] = 8'hFF; bus.normal_data[i] = 8'hEE;
        end
        sel_v = 2'd1; bus.bist_sel = sel_v;
        bus.bist_ce = 1'b1; bus.bist_we = 1'b1; bus.bist_addr = 8'h5A; bus.bist_data = 8'h0A;
        step("bist_mem1", 4'b0010, 4'b0010, 32'h0000_5A00, 32'h0000_0A00, 1, 0, 0);
        sel_v = 2'd3; bus.bist_sel = sel_v; bus.bist_we = 1'b0;
        step("bist_mem3", 4'b1000, 4'b0000, 32'h5A00_0000, 32'h0A00_0000, 1, 0, 0);
        sel_v = 2'd0; bus.bist_sel = sel_v;
        bus.bist_ce = 1'b0; bus.bist_addr = 8'hC3; bus.bist_data = 8'h3C;
        step("bist_mem0_idle", 4'b0, 4'b0, 32'h0000_00C3, 32'h0000_003C, 1, 0, 0);
        sel_v = 2'd2; bus.bist_sel = sel_v;
        bus.bist_ce = 1'b1; bus.bist_we = 1'b1; bus.bist_addr = 8'h77; bus.bist_data = 8'h88;
        step("bist_mem2", 4'b0100, 4'b0100, 32'h0077_0000, 32'h0088_0000, 1, 0, 0);

        clr_in(); bus.NbarT = 1'b0;
        bus.normal_ce = 4'b0101; bus.normal_we = 4'b0100;
        bus.normal_addr[0] = 8'h12; bus.normal_addr[2] = 8'h34;
        bus.normal_data[0] = 8'h56; bus.normal_data[2] = 8'h78;
        step("exit_last_test", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        step("restore_gap1", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        step("restore_gap2", 4'b0, 4'b0, 32'h0, 32'h0, 0, 0, 0);
        step("restore_done", 4'b0101, 4'b0100, 32'h0034_0012, 32'h0078_0056, 0, 0, 0);

        clr_in(); bus.NbarT = 1'b1;
        step("abort_enter", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        step("abort_idle1", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        bus.NbarT = 1'b0;
        bus.normal_ce = 4'b0010; bus.normal_addr[1] = 8'h9C; bus.normal_data[1] = 8'hC9;
        step("abort_exit", 4'b0010, 4'b0, 32'h0000_9C00, 32'h0000_C900, 0, 0, 0);
        step("abort_normal", 4'b0010, 4'b0, 32'h0000_9C00, 32'h0000_C900, 0, 0, 0);
        clr_in(); bus.NbarT = 1'b1;
        step("reenter_drain", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        step("reenter_idle1", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        step("reenter_test", 4'b0, 4'b0, 32'h0, 32'h0, 1, 0, 0);

        bus.NbarT = 1'b0;
        step("restore2_enter", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        bus.NbarT = 1'b1;
        step("restore2_gap1", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        step("restore2_done", 4'b0, 4'b0, 32'h0, 32'h0, 0, 0, 0);
        step("restore2_redrain", 4'b0, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        bus.NbarT = 1'b0;
        step("redrain_abort", 4'b0, 4'b0, 32'h0, 32'h0, 0, 0, 0);

        bus.NbarT = 1'b1; bus.normal_ce = 4'b0001;
        step("to_enter", 4'b0001, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            step("to_wait", 4'b0001, 4'b0, 32'h0, 32'h0, 0, 1, 0);
        end
        step("to_expire", 4'b0001, 4'b0, 32'h0, 32'h0, TO_EN, !TO_EN, TO_EN);
        step("to_hold", TO_EN ? 4'b0000 : 4'b0001, 4'b0, 32'h0, 32'h0, TO_EN, !TO_EN, TO_EN);
        bus.NbarT = 1'b0;
        step("to_exit", TO_EN ? 4'b0000 : 4'b0001, 4'b0, 32'h0, 32'h0, 0, TO_EN, TO_EN);

        rst_n = 1'b0;
        step("reset_mid", 4'b0, 4'b0, 32'h0, 32'h0, 0, 0, 0);
        clr_in(); rst_n = 1'b1;
        bus.normal_ce = 4'b0100; bus.normal_addr[2] = 8'h5C; bus.normal_data[2] = 8'hC5;
        step("post_reset", 4'b0100, 4'b0, 32'h005C_0000, 32'h00C5_0000, 0, 0, 0);

        end_chk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
